// File: rtl/pipeline_key_fill.sv
// Foreground keyer: pixels outside a double-buffered window become KEY_COLOR,
// pixels inside have green clamped to GREEN_PASS. Two-stage pipeline, 1 pixel/cycle.
module pipeline_key_fill #(
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 600,
  parameter logic [5:0]  GREEN_PASS = 6'b010000,
  parameter logic [15:0] KEY_COLOR  = 16'h07E0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pixel_valid,
  input  logic        frame_start,
  input  logic [15:0] fg_pixel_in,
  input  logic [10:0] win_x0,
  input  logic [10:0] win_x1,
  input  logic [10:0] win_y0,
  input  logic [10:0] win_y1,
  input  logic        cfg_load,
  output logic [15:0] pixel_out,
  output logic        pixel_out_valid
);

  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

  function automatic logic [15:0] clamp_green(input logic [15:0] p);
    logic [5:0] g;
    g = (p[10:5] > GREEN_PASS) ? GREEN_PASS : p[10:5];
    return {p[15:11], g, p[4:0]};
  endfunction

  function automatic logic [15:0] key_fill(input logic [15:0] p, input logic en,
                                           input logic inwin);
    if (!en)   return p;
    if (!inwin) return KEY_COLOR;
    return clamp_green(p);
  endfunction

  logic        sof;
  logic [10:0] pos_x, pos_y;
  logic [10:0] x_q, y_q, x_d, y_d;
  logic [10:0] pend_x0_q, pend_x1_q, pend_y0_q, pend_y1_q;
  logic [10:0] pend_x0_d, pend_x1_d, pend_y0_d, pend_y1_d;
  logic [10:0] act_x0_q, act_x1_q, act_y0_q, act_y1_q;
  logic [10:0] act_x0_d, act_x1_d, act_y0_d, act_y1_d;
  logic        inwin;

  logic [15:0] pix_p1_q;
  logic        vld_p1_q, en_p1_q, inwin_p1_q;
  logic [15:0] pix_p2_q;
  logic        vld_p2_q;

  assign sof = pixel_valid & frame_start;

  always_comb begin
    pos_x = sof ? 11'd0 : x_q;
    pos_y = sof ? 11'd0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (pixel_valid) begin
      if (pos_x == X_LAST) begin
        x_d = 11'd0;
        y_d = (pos_y == Y_LAST) ? 11'd0 : pos_y + 11'd1;
      end else begin
        x_d = pos_x + 11'd1;
        y_d = pos_y;
      end
    end
  end

  // A same-cycle load feeds straight through pending into active.
  always_comb begin
    pend_x0_d = cfg_load ? win_x0 : pend_x0_q;
    pend_x1_d = cfg_load ? win_x1 : pend_x1_q;
    pend_y0_d = cfg_load ? win_y0 : pend_y0_q;
    pend_y1_d = cfg_load ? win_y1 : pend_y1_q;
    act_x0_d  = sof ? pend_x0_d : act_x0_q;
    act_x1_d  = sof ? pend_x1_d : act_x1_q;
    act_y0_d  = sof ? pend_y0_d : act_y0_q;
    act_y1_d  = sof ? pend_y1_d : act_y1_q;
    inwin     = (pos_x >= act_x0_d) && (pos_x <= act_x1_d) &&
                (pos_y >= act_y0_d) && (pos_y <= act_y1_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= 11'd0;
      y_q       <= 11'd0;
      pend_x0_q <= 11'd0;
      pend_x1_q <= X_LAST;
      pend_y0_q <= 11'd0;
      pend_y1_q <= Y_LAST;
      act_x0_q  <= 11'd0;
      act_x1_q  <= X_LAST;
      act_y0_q  <= 11'd0;
      act_y1_q  <= Y_LAST;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      pend_x0_q <= pend_x0_d;
      pend_x1_q <= pend_x1_d;
      pend_y0_q <= pend_y0_d;
      pend_y1_q <= pend_y1_d;
      act_x0_q  <= act_x0_d;
      act_x1_q  <= act_x1_d;
      act_y0_q  <= act_y0_d;
      act_y1_q  <= act_y1_d;
    end
  end

  // Stage 1: raw pixel, valid, enable and window flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_p1_q   <= 16'h0000;
      vld_p1_q   <= 1'b0;
      en_p1_q    <= 1'b0;
      inwin_p1_q <= 1'b0;
    end else begin
      pix_p1_q   <= fg_pixel_in;
      vld_p1_q   <= pixel_valid;
      en_p1_q    <= enable;
      inwin_p1_q <= inwin;
    end
  end

  // Stage 2: substituted / clamped result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_p2_q <= 16'h0000;
      vld_p2_q <= 1'b0;
    end else begin
      pix_p2_q <= key_fill(pix_p1_q, en_p1_q, inwin_p1_q);
      vld_p2_q <= vld_p1_q;
    end
  end

  assign pixel_out       = pix_p2_q;
  assign pixel_out_valid = vld_p2_q;

endmodule

// File: doc/pipeline_key_fill.md
# pipeline_key_fill

Foreground-side counterpart to the chroma-key compositor. Takes the active-pixel foreground stream (RGB565) and produces a keyed foreground:
- pixels outside a programmable rectangular window are replaced with the key colour, so the compositor shows background there;
- pixels inside the window are spill-clamped, so their green never triggers the compositor's keep-background test.

It sits directly upstream of the compositor's foreground input.

## Interface
Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- GREEN_PASS, 6'b010000, green threshold used by the compositor; fg green above this selects background
- KEY_COLOR, 16'h07E0, substitution colour (green field 6'b111111 > GREEN_PASS)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = apply window/clamp; 0 = pass fg_pixel_in through unmodified (still delayed)
- pixel_valid  in  1  qualifies fg_pixel_in as an active-area pixel
- frame_start  in  1  marks the first active pixel of a frame; sampled only when pixel_valid=1
- fg_pixel_in  in  16  RGB565 foreground pixel (R[15:11], G[10:5], B[4:0])
- win_x0, win_x1  in  11 each  window columns, inclusive
- win_y0, win_y1  in  11 each  window lines, inclusive
- cfg_load  in  1  one-cycle pulse; captures win_* into the pending registers
- pixel_out  out  16  keyed foreground pixel
- pixel_out_valid  out  1  pixel_valid delayed by 2 cycles

## Operation
- Position counters x (11b) and y (11b) tag each valid pixel.
  - A valid pixel with frame_start=1 is position (0,0).
  - Otherwise a valid pixel is at the current (x,y). After it, x increments.
  - At x = H_ACTIVE-1, x wraps to 0 and y increments. At y = V_ACTIVE-1 with x wrap, y wraps to 0.
  - Cycles with pixel_valid=0 hold the counters.
- Window registers are double-buffered.
  - cfg_load copies win_* to the pending registers.
  - A valid frame_start pixel copies pending to active, and that pixel already uses the new window.
  - If cfg_load and a valid frame_start occur in the same cycle, the just-loaded values go to active directly.
  - Active registers never change mid-frame.
- In-window test: x0 ≤ x ≤ x1 and y0 ≤ y ≤ y1, unsigned. If x0 > x1 or y0 > y1 the window is empty and every pixel is keyed.
- Output rule with enable=1:
  - Outside the window: pixel_out = KEY_COLOR.
  - Inside the window: R and B pass through; G = min(G, GREEN_PASS).
- Output rule with enable=0: pixel_out = fg_pixel_in.
- Pipeline contents when pixel_valid=0: pixel_out shows whatever is in the pipeline. Consumers qualify with pixel_out_valid.

## Timing
- Reset state (asynchronous assertion, immediate):
  - x, y = 0.
  - Pending and active window = (0, H_ACTIVE-1, 0, V_ACTIVE-1), i.e. full screen.
  - All pipeline registers = 0, so pixel_out = 16'h0000 and pixel_out_valid = 0.
  - A reset mid-frame discards both in-flight pixels.
- Latency: exactly 2 clk cycles from fg_pixel_in/pixel_valid to pixel_out/pixel_out_valid. Throughput is 1 pixel/cycle, with no stall or backpressure.
  - Stage 1 registers the pixel, valid, enable and the in-window flag computed from the pixel's own (x,y) and the active window, including any shadow update in that same cycle.
  - Stage 2 registers the substituted/clamped result.
- enable is sampled per pixel at stage 1, so switching takes effect on a pixel boundary with no glitch.
- A frame_start arriving early (before y wraps) resynchronises the counters with no error signalling. A missing frame_start lets the counters wrap naturally.

## Test plan
- Full-screen window after reset, enable=1. Stream 0xF81F then 0x07E0 → outputs 0xF81F then 0x0200 (G clamped to 16), valid exactly 2 cycles after input.
- cfg_load window x 2..4, y 1..1, then frame_start; H_ACTIVE=8, V_ACTIVE=4 (override), constant input 0x001F → only line 1, columns 2–4 output 0x001F; all others 0x07E0.
- cfg_load mid-frame with a new window → the current frame keeps the old window; the change appears from the next frame_start pixel.
- win_x0=5, win_x1=3 → every pixel of the frame = 0x07E0. enable=0 on the same stream → output equals input.
- Gaps in pixel_valid (1 on, 2 off, repeating) → positions still advance only on valid pixels, and the window edges land on the same columns as the gapless case.
- Assert rst for 1 cycle mid-line → pixel_out=0 and pixel_out_valid=0 immediately; after release the window is full screen and the counters restart at (0,0).
